// File: rtl/ofm_writer_if.sv
// ----------------------------------------------------------------------------
// ofm_writer_if
// Result stream from the PE array into the OFM writer (valid/ready).
//   res_valid : producer has a result word
//   res_data  : result word (DATA_W bits)
//   res_ready : writer accepts res_data this cycle
// Modports: master = PE result producer, slave = ofm_writer.
// ----------------------------------------------------------------------------
interface ofm_writer_if #(
    parameter int DATA_W = 32
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    modport master (
        output res_valid,
        output res_data,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        output res_ready
    );
endinterface

// File: rtl/ofm_writer.sv
// ----------------------------------------------------------------------------
// ofm_writer
// Buffers the PE result stream in a small FIFO and drives the layer OFM
// store write port (adr/in/we) with sequential addresses from a base.
// When every word of the layer has been issued it raises the level
// done/number pair the store waits on before dumping its file.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle pulse, sampled only in IDLE/DONE
//   base_adr            first write address (latched on start)
//   word_cnt            words to write this layer (latched on start)
//   layer_num           layer index, reported on number when done
//   res                 result stream (ofm_writer_if.slave)
//   mem_hold            store busy: no write issues while high
//   adr / in / we       registered store write port
//   done / number       level completion flag and latched layer index
//   busy                high while a layer is running
//   err_overrun         sticky: an out-of-range write was suppressed
//
// Configuration macro OFM_WR_RELU_EN: when defined, words with MSB set
// (signed negative) are replaced by zero on their way to the store.
// ----------------------------------------------------------------------------
module ofm_writer #(
    parameter int DATA_W     = 32,
    parameter int ADR_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADR_W-1:0]  base_adr,
    input  logic [31:0]       word_cnt,
    input  logic [31:0]       layer_num,
    ofm_writer_if.slave       res,
    input  logic              mem_hold,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] in,
    output logic              we,
    output logic              done,
    output logic [31:0]       number,
    output logic              busy,
    output logic              err_overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Extra bit so addresses equal to 2^ADR_W-1 still compare correctly.
    localparam logic [ADR_W:0] MEM_LIMIT = (ADR_W+1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADR_W-1:0]  base_r;
    logic [31:0]       count_r;
    logic [31:0]       layer_r;
    logic [31:0]       acc_cnt_r;
    logic [31:0]       wr_cnt_r;
    logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
    // Pointers carry one wrap bit to tell full from empty.
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              res_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_raw_s;
    logic [DATA_W-1:0] head_s;
    logic [ADR_W-1:0]  wr_adr_s;
    logic              in_range_s;
    logic              done_cond_s;

    // FIFO status, handshake, pop decision and write address generation.
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

        if (state_r == ST_RUN) begin
            res_ready_s = !fifo_full_s && (acc_cnt_r < count_r);
            pop_s       = !fifo_empty_s && !mem_hold;
        end else begin
            res_ready_s = 1'b0;
            pop_s       = 1'b0;
        end
        push_s = res.res_valid && res_ready_s;

        head_raw_s = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
`ifdef OFM_WR_RELU_EN
        if (head_raw_s[DATA_W-1]) begin
            head_s = '0;
        end else begin
            head_s = head_raw_s;
        end
`else
        head_s = head_raw_s;
`endif

        // Address wraps modulo 2^ADR_W; range check happens after the wrap.
        wr_adr_s    = base_r + ADR_W'(wr_cnt_r);
        in_range_s  = ({1'b0, wr_adr_s} < MEM_LIMIT);
        done_cond_s = (wr_cnt_r == count_r) && fifo_empty_s;
    end

    assign res.res_ready = res_ready_s;

    // Layer FSM, result FIFO and registered store write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            count_r     <= 32'd0;
            layer_r     <= 32'd0;
            acc_cnt_r   <= 32'd0;
            wr_cnt_r    <= 32'd0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            adr         <= '0;
            in          <= '0;
            we          <= 1'b0;
            done        <= 1'b0;
            number      <= 32'd0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            we <= 1'b0;

            if (push_s) begin
                fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= res.res_data;
                wr_ptr_r  <= wr_ptr_r + (PTR_W+1)'(1);
                acc_cnt_r <= acc_cnt_r + 32'd1;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
                wr_cnt_r <= wr_cnt_r + 32'd1;
                // Out-of-range words are consumed and counted but never written.
                if (in_range_s) begin
                    we  <= 1'b1;
                    in  <= head_s;
                    adr <= wr_adr_s;
                end else begin
                    err_overrun <= 1'b1;
                end
            end

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_r      <= base_adr;
                        count_r     <= word_cnt;
                        layer_r     <= layer_num;
                        acc_cnt_r   <= 32'd0;
                        wr_cnt_r    <= 32'd0;
                        wr_ptr_r    <= '0;
                        rd_ptr_r    <= '0;
                        err_overrun <= 1'b0;
                        if (word_cnt != 32'd0) begin
                            state_r <= ST_RUN;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            number  <= layer_num;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while a layer is running.
                    if (done_cond_s) begin
                        state_r <= ST_DONE;
                        done    <= 1'b1;
                        number  <= layer_r;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
